// File: rtl/bram_pkg.sv
// Shared types and defaults for the banked BRAM block and its readers.
package bram_pkg;

    localparam int unsigned BRAM_ADDR_WIDTH_DEF = 10;
    localparam int unsigned BANK_DATA_WIDTH_DEF = 8;
    localparam int unsigned BANK_CNT_DEF        = 4;
    localparam int unsigned RD_LATENCY_DEF      = 1;

    // ceil(log2(n)), never below one bit so single-entry counters stay legal
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned LANE_W = clog2_min1(BANK_CNT_DEF);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SHIFT,
        DONE
    } rd_state_t;

    // One BRAM word as seen on bram_block dout: lane 0 in the low bits
    typedef logic [BANK_CNT_DEF-1:0][BANK_DATA_WIDTH_DEF-1:0] bram_word_t;

endpackage

// File: rtl/bram_block_reader_if.sv
// Lane-serial valid/ready stream carrying BRAM lanes to a consumer.
interface bram_block_reader_if
    import bram_pkg::*;
#(
    parameter int unsigned DW = BANK_DATA_WIDTH_DEF
) ();

    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/bram_lane_serializer.sv
// Holds one fetched BRAM word and presents its lanes one per handshake, lane 0 first.
module bram_lane_serializer
    import bram_pkg::*;
#(
    parameter int unsigned BANK_DATA_WIDTH = BANK_DATA_WIDTH_DEF,
    parameter int unsigned BANK_CNT        = BANK_CNT_DEF
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    load,
    input  logic [BANK_CNT-1:0][BANK_DATA_WIDTH-1:0] din,
    input  logic                                    m_ready,
    output logic [BANK_DATA_WIDTH-1:0]              m_data,
    output logic                                    m_valid,
    output logic                                    lane_last_c,
    output logic                                    word_done_c
);

    localparam int unsigned LW = clog2_min1(BANK_CNT);
    localparam logic [LW-1:0] LANE_LAST = LW'(BANK_CNT - 1);

    logic [BANK_CNT-1:0][BANK_DATA_WIDTH-1:0] word_q;
    logic [LW-1:0]                            lane_q;
    logic                                     valid_q;
    logic                                     fire_c;

    // Word capture on load, lane advance on each accepted beat
    always_ff @(posedge clock) begin
        if (reset) begin
            word_q  <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            word_q  <= din;
            lane_q  <= '0;
            valid_q <= 1'b1;
        end else if (fire_c) begin
            if (lane_q == LANE_LAST) begin
                lane_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                lane_q  <= lane_q + LW'(1);
            end
        end
    end

    // Stream view decoded from held state; only word_done_c sees m_ready
    always_comb begin
        fire_c      = valid_q && m_ready;
        lane_last_c = (lane_q == LANE_LAST);
        word_done_c = fire_c && lane_last_c;
        m_valid     = valid_q;
        m_data      = word_q[lane_q];
    end

endmodule

// File: rtl/bram_block_reader.sv
// Read-side master: fetches word_cnt BRAM words from base_addr and streams their lanes.
module bram_block_reader
    import bram_pkg::*;
#(
    parameter int unsigned BRAM_ADDR_WIDTH = BRAM_ADDR_WIDTH_DEF,
    parameter int unsigned BANK_DATA_WIDTH = BANK_DATA_WIDTH_DEF,
    parameter int unsigned BANK_CNT        = BANK_CNT_DEF,
    parameter int unsigned RD_LATENCY      = RD_LATENCY_DEF
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [BRAM_ADDR_WIDTH-1:0]              base_addr,
    input  logic [BRAM_ADDR_WIDTH:0]                word_cnt,
    output logic                                    busy,
    output logic                                    done,
    output logic [BRAM_ADDR_WIDTH-1:0]              rd_addr,
    input  logic [BANK_CNT-1:0][BANK_DATA_WIDTH-1:0] bram_dout,
    bram_block_reader_if.master                     m
);

    localparam int unsigned AW    = BRAM_ADDR_WIDTH;
    localparam int unsigned REM_W = BRAM_ADDR_WIDTH + 1;
    localparam int unsigned LAT_W = clog2_min1(RD_LATENCY);

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [AW-1:0]     addr_q;
    logic [REM_W-1:0]  rem_q;
    logic [LAT_W-1:0]  lat_q;

    logic              lat_last_c;
    logic              rem_last_c;
    logic              load_c;
    logic              word_done_c;
    logic              lane_last_c;
    logic [BANK_DATA_WIDTH-1:0] ser_data;
    logic              ser_valid;

    assign lat_last_c = (lat_q == LAT_W'(RD_LATENCY - 1));
    assign rem_last_c = (rem_q == REM_W'(1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a zero-length request still produces its done pulse
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (word_cnt == '0) ? DONE : READ;
            READ:    state_d = WAIT;
            WAIT:    if (lat_last_c) state_d = SHIFT;
            SHIFT:   if (word_done_c) state_d = rem_last_c ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs and the word capture strobe
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        load_c = (state_q == WAIT) && lat_last_c;
    end

    // Address, remaining-word and read-latency bookkeeping; address wraps modulo memory size
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            rem_q  <= '0;
            lat_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q <= base_addr;
                        rem_q  <= word_cnt;
                    end
                end
                READ:  lat_q <= '0;
                WAIT:  lat_q <= lat_q + LAT_W'(1);
                SHIFT: begin
                    if (word_done_c && !rem_last_c) begin
                        addr_q <= addr_q + AW'(1);
                        rem_q  <= rem_q - REM_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_addr = addr_q;

    bram_lane_serializer #(
        .BANK_DATA_WIDTH (BANK_DATA_WIDTH),
        .BANK_CNT        (BANK_CNT)
    ) u_ser (
        .clock       (clock),
        .reset       (reset),
        .load        (load_c),
        .din         (bram_dout),
        .m_ready     (m.m_ready),
        .m_data      (ser_data),
        .m_valid     (ser_valid),
        .lane_last_c (lane_last_c),
        .word_done_c (word_done_c)
    );

    // Stream outputs; last marks the final lane of the final word
    always_comb begin
        m.m_data  = ser_data;
        m.m_valid = ser_valid;
        m.m_last  = ser_valid && lane_last_c && rem_last_c;
    end

endmodule
